// File: rtl/alu_core_pkg.sv
// Shared ALU definitions: datapath widths, func opcodes, flag bit indices and
// a signed-overflow helper. Reused by the decode and forwarding stages.
package alu_core_pkg;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned FUNC_W = 4;
   localparam int unsigned FLAG_W = 4;
   localparam int unsigned EXT_W  = WIDTH + 1;

   typedef logic [WIDTH-1:0]  word_t;
   typedef logic [FUNC_W-1:0] func_t;
   typedef logic [FLAG_W-1:0] flags_t;

   localparam func_t ALU_NOP  = 4'b0000;
   localparam func_t ALU_SETC = 4'b0001;
   localparam func_t ALU_CLRC = 4'b0010;
   localparam func_t ALU_MOV1 = 4'b0011;
   localparam func_t ALU_MOV2 = 4'b0100;
   localparam func_t ALU_NOT  = 4'b0101;
   localparam func_t ALU_INC  = 4'b0110;
   localparam func_t ALU_DEC  = 4'b0111;
   localparam func_t ALU_ADD  = 4'b1000;
   localparam func_t ALU_SUB  = 4'b1001;
   localparam func_t ALU_AND  = 4'b1010;
   localparam func_t ALU_OR   = 4'b1011;
   localparam func_t ALU_SHL  = 4'b1100;
   localparam func_t ALU_SHR  = 4'b1101;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   // Two's-complement overflow of a +/- b = r, given the operand sign bits.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
      logic b_eff;
      b_eff = is_sub ? ~b_msb : b_msb;
      return (a_msb == b_eff) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_core_if.sv
// ALU operand/result bundle.
//   op1, op2 : operands (op2 also carries the shift amount)
//   func     : operation select
//   result   : combinational result
//   outFlags : registered flags {12'b0, V, C, N, Z}
// master drives operands; slave is the ALU.
interface alu_core_if;
   import alu_core_pkg::*;

   word_t op1;
   word_t op2;
   func_t func;
   word_t result;
   word_t outFlags;

   modport master (output op1, output op2, output func,
                   input  result, input outFlags);
   modport slave  (input  op1, input  op2, input  func,
                   output result, output outFlags);
endinterface

// File: rtl/alu_flag_reg.sv
// Condition flag register with per-flag write enables.
//   clk, rst   : clock, async active-high reset (clears all flags)
//   flag_we    : per-flag write enable
//   flag_nxt   : candidate next flag values
//   flags      : current flag register contents
module alu_flag_reg
   import alu_core_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  flags_t flag_we,
   input  flags_t flag_nxt,
   output flags_t flags
);

   flags_t flags_d;
   flags_t flags_q;

   // Enabled bits take the new value, the rest hold.
   always_comb begin
      flags_d = flags_q;
      for (int i = 0; i < int'(FLAG_W); i++) begin
         if (flag_we[i]) begin
            flags_d[i] = flag_nxt[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;

endmodule

// File: rtl/alu_core.sv
// 16-bit execute-stage ALU: combinational result, registered Z/N/C/V flags.
//   clk, rst : clock, async active-high reset of the flag register
//   bus      : slave side of alu_core_if (op1, op2, func in; result, outFlags out)
module alu_core
   import alu_core_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   alu_core_if.slave  bus
);

   word_t              arith_b;
   logic [EXT_W-1:0]   sum_w;
   logic [EXT_W-1:0]   diff_w;
   logic [EXT_W-1:0]   shl_w;
   logic [EXT_W-1:0]   shr_w;
   logic [3:0]         sh;
   word_t              res;
   logic               zn_we;
   flags_t             flag_we;
   flags_t             flag_nxt;
   flags_t             flags;

   // INC/DEC reuse the adder/subtractor with a constant 1.
   assign arith_b = (bus.func == ALU_INC || bus.func == ALU_DEC) ? WIDTH'(1) : bus.op2;
   assign sum_w   = {1'b0, bus.op1} + {1'b0, arith_b};
   assign diff_w  = {1'b0, bus.op1} - {1'b0, arith_b};

   // Extra bit catches the last bit shifted out: op1[16-sh] / op1[sh-1].
   assign sh    = bus.op2[3:0];
   assign shl_w = {1'b0, bus.op1} << sh;
   assign shr_w = {bus.op1, 1'b0} >> sh;

   // Result select and flag next-state / write enables.
   always_comb begin
      res      = '0;
      zn_we    = 1'b0;
      flag_we  = '0;
      flag_nxt = '0;
      unique case (bus.func)
         ALU_SETC: begin
            flag_we[FLAG_C]  = 1'b1;
            flag_nxt[FLAG_C] = 1'b1;
         end
         ALU_CLRC: begin
            flag_we[FLAG_C]  = 1'b1;
            flag_nxt[FLAG_C] = 1'b0;
         end
         ALU_MOV1: res = bus.op1;
         ALU_MOV2: res = bus.op2;
         ALU_NOT: begin
            res   = ~bus.op1;
            zn_we = 1'b1;
         end
         ALU_INC, ALU_ADD: begin
            res              = sum_w[WIDTH-1:0];
            zn_we            = 1'b1;
            flag_we[FLAG_C]  = 1'b1;
            flag_we[FLAG_V]  = 1'b1;
            flag_nxt[FLAG_C] = sum_w[WIDTH];
            flag_nxt[FLAG_V] = signed_ovf(bus.op1[WIDTH-1], arith_b[WIDTH-1],
                                          sum_w[WIDTH-1], 1'b0);
         end
         ALU_DEC, ALU_SUB: begin
            res              = diff_w[WIDTH-1:0];
            zn_we            = 1'b1;
            flag_we[FLAG_C]  = 1'b1;
            flag_we[FLAG_V]  = 1'b1;
            flag_nxt[FLAG_C] = diff_w[WIDTH];
            flag_nxt[FLAG_V] = signed_ovf(bus.op1[WIDTH-1], arith_b[WIDTH-1],
                                          diff_w[WIDTH-1], 1'b1);
         end
         ALU_AND: begin
            res   = bus.op1 & bus.op2;
            zn_we = 1'b1;
         end
         ALU_OR: begin
            res   = bus.op1 | bus.op2;
            zn_we = 1'b1;
         end
         ALU_SHL: begin
            res              = shl_w[WIDTH-1:0];
            zn_we            = 1'b1;
            flag_we[FLAG_C]  = (sh != 4'd0);
            flag_nxt[FLAG_C] = shl_w[WIDTH];
         end
         ALU_SHR: begin
            res              = shr_w[WIDTH:1];
            zn_we            = 1'b1;
            flag_we[FLAG_C]  = (sh != 4'd0);
            flag_nxt[FLAG_C] = shr_w[0];
         end
         default: res = '0;
      endcase
      flag_we[FLAG_Z]  = zn_we;
      flag_we[FLAG_N]  = zn_we;
      flag_nxt[FLAG_Z] = (res == '0);
      flag_nxt[FLAG_N] = res[WIDTH-1];
   end

   alu_flag_reg u_flag_reg (
      .clk      (clk),
      .rst      (rst),
      .flag_we  (flag_we),
      .flag_nxt (flag_nxt),
      .flags    (flags)
   );

   assign bus.result   = res;
   assign bus.outFlags = {{(WIDTH-FLAG_W){1'b0}}, flags};

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed steps followed by random vectors,
// compared against an integer-arithmetic reference model.
module tb_alu_core;
   import alu_core_pkg::*;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   // Reference flag state.
   bit m_z, m_n, m_c, m_v;

   alu_core_if bus ();

   alu_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int to_signed16(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   function automatic int model_result(input int f, input int a, input int b);
      int sh;
      sh = b % 16;
      case (f)
         3:  return a;
         4:  return b;
         5:  return (~a) & 'hFFFF;
         6:  return (a + 1) & 'hFFFF;
         7:  return (a - 1) & 'hFFFF;
         8:  return (a + b) & 'hFFFF;
         9:  return (a - b) & 'hFFFF;
         10: return a & b;
         11: return a | b;
         12: return (a << sh) & 'hFFFF;
         13: return a >> sh;
         default: return 0;
      endcase
   endfunction

   // Flag effect of one clock edge under func f.
   task automatic model_clock(input int f, input int a, input int b);
      int r, sh, bb, s;
      r  = model_result(f, a, b);
      sh = b % 16;
      bb = (f == 6 || f == 7) ? 1 : b;
      if (f >= 5 && f <= 13) begin
         m_z = (r == 0);
         m_n = (r >= 32768);
      end
      case (f)
         1: m_c = 1'b1;
         2: m_c = 1'b0;
         6, 8: begin
            m_c = (a + bb) > 65535;
            s   = to_signed16(a) + to_signed16(bb);
            m_v = (s > 32767) || (s < -32768);
         end
         7, 9: begin
            m_c = (a < bb);
            s   = to_signed16(a) - to_signed16(bb);
            m_v = (s > 32767) || (s < -32768);
         end
         12: if (sh != 0) m_c = ((a >> (16 - sh)) & 1) != 0;
         13: if (sh != 0) m_c = ((a >> (sh - 1)) & 1) != 0;
         default: ;
      endcase
   endtask

   function automatic logic [15:0] model_flags();
      return 16'(int'(m_z) + 2 * int'(m_n) + 4 * int'(m_c) + 8 * int'(m_v));
   endfunction

   // Drive one operation, check result, clock it, check flags.
   task automatic step(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.func = f;
      bus.op1  = a;
      bus.op2  = b;
      #1;
      chk($sformatf("result f=%0d a=%h b=%h", f, a, b), bus.result,
          16'(model_result(int'(f), int'(a), int'(b))));
      @(posedge clk);
      model_clock(int'(f), int'(a), int'(b));
      #1;
      chk($sformatf("flags f=%0d a=%h b=%h", f, a, b), bus.outFlags, model_flags());
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_z = 0; m_n = 0; m_c = 0; m_v = 0;
      rst      = 1'b1;
      bus.func = ALU_NOP;
      bus.op1  = '0;
      bus.op2  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset flags", bus.outFlags, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      step(ALU_ADD, 16'h0001, 16'h0001);
      chk("add result", bus.result, 16'h0002);
      chk("add flags", bus.outFlags, 16'h0000);
      step(ALU_SUB, 16'h0001, 16'h0001);
      chk("sub result", bus.result, 16'h0000);
      chk("sub flags", bus.outFlags, 16'h0001);
      step(ALU_OR, 16'h0003, 16'h0005);
      chk("or result", bus.result, 16'h0007);
      step(ALU_NOT, 16'h00F0, 16'h0000);
      chk("not result", bus.result, 16'hFF0F);
      chk("not flags", bus.outFlags, 16'h0002);
      step(ALU_MOV1, 16'h00F0, 16'h1234);
      chk("mov1 result", bus.result, 16'h00F0);
      step(ALU_MOV2, 16'h5555, 16'h0F0F);
      chk("mov2 result", bus.result, 16'h0F0F);
      chk("mov2 flags", bus.outFlags, 16'h0002);
      step(ALU_SHL, 16'h8001, 16'h0001);
      chk("shl result", bus.result, 16'h0002);
      chk("shl flags", bus.outFlags, 16'h0004);
      step(ALU_SHR, 16'h0003, 16'h0001);
      chk("shr result", bus.result, 16'h0001);
      chk("shr flags", bus.outFlags, 16'h0004);
      step(ALU_SHL, 16'h0000, 16'h0010);
      chk("shl0 result", bus.result, 16'h0000);
      chk("shl0 flags", bus.outFlags, 16'h0005);
      step(ALU_INC, 16'h7FFF, 16'h0000);
      chk("inc result", bus.result, 16'h8000);
      chk("inc flags", bus.outFlags, 16'h000A);
      step(ALU_DEC, 16'h0000, 16'h0000);
      chk("dec result", bus.result, 16'hFFFF);
      chk("dec flags", bus.outFlags, 16'h0006);
      for (int i = 0; i < 3; i++) begin
         step(ALU_NOP, 16'hABCD, 16'h1234);
         chk("nop flags", bus.outFlags, 16'h0006);
      end
      for (int i = 0; i < 2; i++) begin
         step(4'b1111, 16'hFFFF, 16'hFFFF);
         chk("rsv result", bus.result, 16'h0000);
         chk("rsv flags", bus.outFlags, 16'h0006);
      end

      // Async reset between edges.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst flags", bus.outFlags, 16'h0000);
      m_z = 0; m_n = 0; m_c = 0; m_v = 0;
      #1 rst = 1'b0;

      step(ALU_SUB, 16'h0001, 16'h0001);
      step(ALU_SETC, 16'h0000, 16'h0000);
      chk("setc flags", bus.outFlags, 16'h0005);
      step(ALU_CLRC, 16'h0000, 16'h0000);
      chk("clrc flags", bus.outFlags, 16'h0001);

      for (int i = 0; i < 400; i++) begin
         logic [3:0]  f;
         logic [15:0] a, b;
         f = 4'($urandom_range(0, 15));
         a = 16'($urandom);
         b = 16'($urandom);
         if (($urandom & 3) == 0) a = 16'($urandom_range(0, 3)) | ((($urandom & 1) != 0) ? 16'h8000 : 16'h7FFC);
         if (($urandom & 3) == 0) b = 16'($urandom_range(0, 2));
         step(f, a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 16-bit integer ALU for the execute stage of the five-stage pipeline processor.
- Result is purely combinational from op1, op2 and func.
- Condition flags are held in an internal flag register, updated on the clock edge by flag-affecting operations, and exposed on outFlags.

Parameters:
- WIDTH, 16, datapath width of op1, op2, result and outFlags.

Ports:
- clk  input  1  rising-edge clock; updates the flag register.
- rst  input  1  asynchronous active-high reset; clears the flag register.
- op1  input  16  first operand (source / destination value).
- op2  input  16  second operand (register or immediate; shift amount).
- func  input  4  operation select.
- result  output  16  combinational operation result.
- outFlags  output  16  flag register: bit0 Z, bit1 N, bit2 C, bit3 V; bits 15:4 always 0.

Behaviour:
- result is combinational, zero latency; it is valid within the same delta after op1, op2 or func change.
- func encoding and effect on result:
  - 0000 NOP: result 0.
  - 0001 SETC: result 0; C set to 1.
  - 0010 CLRC: result 0; C cleared to 0.
  - 0011 MOV1: result = op1.
  - 0100 MOV2: result = op2.
  - 0101 NOT: result = ~op1.
  - 0110 INC: result = op1+1.
  - 0111 DEC: result = op1-1.
  - 1000 ADD: result = op1+op2.
  - 1001 SUB: result = op1-op2.
  - 1010 AND: result = op1&op2.
  - 1011 OR: result = op1|op2.
  - 1100 SHL: result = op1 << op2[3:0].
  - 1101 SHR: result = op1 >> op2[3:0], logical (zero fill).
  - 1110, 1111 reserved: result 0.
- Flag update rules (next-flag computed combinationally, latched on rising clk):
  - ADD, SUB, INC, DEC update Z, N, C and V.
  - C is the carry-out for ADD and INC. C is the borrow for SUB and DEC (1 when unsigned op1 < subtrahend).
  - V is signed two's-complement overflow of the 16-bit result.
  - NOT, AND, OR update Z and N only; C and V hold.
  - SHL/SHR update Z and N. C takes the last bit shifted out: op1[16-sh] for SHL, op1[sh-1] for SHR. With sh = 0, result = op1 and C holds. V holds.
  - NOP, MOV1, MOV2 and reserved codes leave all flags unchanged.
  - SETC/CLRC change only C.
- Z = (result == 0); N = result[15].
- rst asserted: outFlags = 16'h0000 immediately, regardless of clk. The first edge after rst deasserts applies the func present at that edge.
- All arithmetic wraps modulo 2^16; no saturation.

Decomposition:
- Shared package holds the func opcode localparams (ALU_NOP … ALU_SHR) and the flag bit index constants (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3); the decode and forwarding stages reuse them.
- One natural sub-module, alu_flag_reg: a 4-bit flag register with per-flag write enables and async reset. Combinational operation logic stays in alu_core.

Test Plan:
- ADD 0x0001+0x0001 -> result 0x0002; after clk, Z=0, N=0, C=0, V=0. SUB 0x0001-0x0001 -> result 0x0000, Z=1, C=0.
- OR 0x0003|0x0005 -> result 0x0007. NOT op1=0x00F0 -> result 0xFF0F with N=1. MOV1 op1=0x00F0 -> result 0x00F0. MOV2 op2=0x0F0F -> result 0x0F0F; flags unchanged across clk.
- SHL 0x8001 by 1 -> result 0x0002, C=1. SHR 0x0003 by 1 -> result 0x0001, C=1. Shift by 0 -> result = op1, C unchanged.
- INC 0x7FFF -> result 0x8000, V=1, N=1. DEC 0x0000 -> result 0xFFFF, N=1, C=1, V=0.
- NOP after a flag-setting op -> result 0x0000, outFlags identical to the previous value after several clocks. Reserved code 1111 behaves the same.
- Assert rst between clock edges with flags nonzero -> outFlags 0x0000 immediately. SETC then CLRC -> C=1 then C=0, with other flags untouched.
